// File: rtl/csoc_scan_loader_pkg.sv
// rtl/csoc_scan_loader_pkg.sv - ASCII command/ack constants and FSM encoding for the CSoC debug port
package csoc_scan_loader_pkg;

  // Command bytes received from the UART
  localparam logic [7:0] CMD_L   = 8'h4C;  // "L": shift a 0 into the chain
  localparam logic [7:0] CMD_H   = 8'h48;  // "H": shift a 1 into the chain
  localparam logic [7:0] CMD_R   = 8'h52;  // "R": pulse CSoC reset
  localparam logic [7:0] CMD_G   = 8'h47;  // "G": run CSoC functionally
  localparam logic [7:0] CMD_X   = 8'h58;  // "X": clear the bit counter

  // Whitespace bytes that are silently skipped
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_SP  = 8'h20;

  // Acknowledge bytes sent back on the UART
  localparam logic [7:0] ACK_OK  = 8'h4B;  // "K"
  localparam logic [7:0] ACK_ERR = 8'h3F;  // "?"

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SH_SETUP  = 3'd1,
    S_SH_HIGH   = 3'd2,
    S_RST_PULSE = 3'd3,
    S_RUN_LO    = 3'd4,
    S_RUN_HI    = 3'd5,
    S_SEND_ACK  = 3'd6
  } state_t;

endpackage

// File: rtl/csoc_scan_loader.sv
// rtl/csoc_scan_loader.sv - UART command decoder driving the CSoC scan chain, reset and functional clock
module csoc_scan_loader
  import csoc_scan_loader_pkg::*;
#(
  parameter int NUM_OF_REGS   = 20,
  parameter int RUNNING_TICKS = 6,
  parameter int RST_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       new_rx_data_i,
  input  logic       tx_ready_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       csoc_clk_o,
  output logic       csoc_rstn_o,
  output logic       csoc_test_se_o,
  output logic       csoc_test_tm_o,
  output logic       csoc_scan_in_o,
  output logic       busy_o,
  output logic       overrun_o
);

  localparam int BIT_W  = $clog2(NUM_OF_REGS + 1);
  localparam int TICK_W = $clog2(RUNNING_TICKS + 1);
  localparam int RST_W  = $clog2(RST_CYCLES + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NUM_OF_REGS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RUNNING_TICKS);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);

  state_t            state, state_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_nxt;
  logic [RST_W-1:0]  rst_cnt, rst_cnt_nxt;

  logic       tx_start_nxt;
  logic [7:0] tx_data_nxt;
  logic       clk_nxt;
  logic       rstn_nxt;
  logic       se_nxt;
  logic       tm_nxt;
  logic       scan_in_nxt;
  logic       overrun_nxt;

  // State, counters and every output are registered from the next-state logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      bit_cnt        <= '0;
      tick_cnt       <= '0;
      rst_cnt        <= '0;
      tx_start_o     <= 1'b0;
      tx_data_o      <= ACK_OK;
      csoc_clk_o     <= 1'b0;
      csoc_rstn_o    <= 1'b0;
      csoc_test_se_o <= 1'b1;
      csoc_test_tm_o <= 1'b1;
      csoc_scan_in_o <= 1'b0;
      busy_o         <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      state          <= state_nxt;
      bit_cnt        <= bit_cnt_nxt;
      tick_cnt       <= tick_cnt_nxt;
      rst_cnt        <= rst_cnt_nxt;
      tx_start_o     <= tx_start_nxt;
      tx_data_o      <= tx_data_nxt;
      csoc_clk_o     <= clk_nxt;
      csoc_rstn_o    <= rstn_nxt;
      csoc_test_se_o <= se_nxt;
      csoc_test_tm_o <= tm_nxt;
      csoc_scan_in_o <= scan_in_nxt;
      busy_o         <= (state_nxt != S_IDLE);
      overrun_o      <= overrun_nxt;
    end
  end

  // Command decode and sequencing; idle levels are the defaults, states override them
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    tick_cnt_nxt = tick_cnt;
    rst_cnt_nxt  = rst_cnt;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data_o;
    clk_nxt      = 1'b0;
    rstn_nxt     = 1'b1;
    se_nxt       = 1'b1;
    tm_nxt       = 1'b1;
    scan_in_nxt  = csoc_scan_in_o;
    // Any strobe outside IDLE (including the cycle that returns to IDLE) is dropped
    overrun_nxt  = overrun_o | (new_rx_data_i && (state != S_IDLE));

    case (state)
      S_IDLE: begin
        if (new_rx_data_i) begin
          case (rx_data_i)
            CMD_L: begin
              scan_in_nxt = 1'b0;
              state_nxt   = S_SH_SETUP;
            end
            CMD_H: begin
              scan_in_nxt = 1'b1;
              state_nxt   = S_SH_SETUP;
            end
            CMD_R: begin
              rst_cnt_nxt = '0;
              rstn_nxt    = 1'b0;
              state_nxt   = S_RST_PULSE;
            end
            CMD_G: begin
              tick_cnt_nxt = '0;
              se_nxt       = 1'b0;
              tm_nxt       = 1'b0;
              state_nxt    = S_RUN_LO;
            end
            CMD_X: begin
              bit_cnt_nxt = '0;
              tx_data_nxt = ACK_OK;
              state_nxt   = S_SEND_ACK;
            end
            CHR_LF, CHR_CR, CHR_SP: begin
              state_nxt = S_IDLE;
            end
            default: begin
              tx_data_nxt = ACK_ERR;
              state_nxt   = S_SEND_ACK;
            end
          endcase
        end
      end

      // Scan data has been stable for a full low phase; raise the scan clock
      S_SH_SETUP: begin
        clk_nxt   = 1'b1;
        state_nxt = S_SH_HIGH;
      end

      S_SH_HIGH: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt = '0;
          tx_data_nxt = ACK_OK;
          state_nxt   = S_SEND_ACK;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          state_nxt   = S_IDLE;
        end
      end

      S_RST_PULSE: begin
        if (rst_cnt == RST_LAST) begin
          bit_cnt_nxt = '0;
          tx_data_nxt = ACK_OK;
          state_nxt   = S_SEND_ACK;
        end else begin
          rst_cnt_nxt = rst_cnt + 1'b1;
          rstn_nxt    = 1'b0;
        end
      end

      S_RUN_LO: begin
        se_nxt       = 1'b0;
        tm_nxt       = 1'b0;
        clk_nxt      = 1'b1;
        tick_cnt_nxt = tick_cnt + 1'b1;
        state_nxt    = S_RUN_HI;
      end

      // Clock falls here; test controls are restored only on this falling transition
      S_RUN_HI: begin
        if (tick_cnt == TICK_LAST) begin
          tx_data_nxt = ACK_OK;
          state_nxt   = S_SEND_ACK;
        end else begin
          se_nxt    = 1'b0;
          tm_nxt    = 1'b0;
          state_nxt = S_RUN_LO;
        end
      end

      S_SEND_ACK: begin
        if (tx_ready_i) begin
          tx_start_nxt = 1'b1;
          state_nxt    = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csoc_scan_loader.sv
// tb/tb_csoc_scan_loader.sv - directed, table-driven bench for csoc_scan_loader
module tb_csoc_scan_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       new_rx;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       csoc_clk;
  logic       csoc_rstn;
  logic       se;
  logic       tm;
  logic       scan_in;
  logic       busy;
  logic       overrun;

  csoc_scan_loader dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data_i      (rx_data),
    .new_rx_data_i  (new_rx),
    .tx_ready_i     (tx_ready),
    .tx_start_o     (tx_start),
    .tx_data_o      (tx_data),
    .csoc_clk_o     (csoc_clk),
    .csoc_rstn_o    (csoc_rstn),
    .csoc_test_se_o (se),
    .csoc_test_tm_o (tm),
    .csoc_scan_in_o (scan_in),
    .busy_o         (busy),
    .overrun_o      (overrun)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Passive monitor: running totals sampled on the falling edge
  int         rises     = 0;
  int         run_rises = 0;
  int         tx_cnt    = 0;
  int         rstn_low  = 0;
  int         se_viol   = 0;
  int         tx_long   = 0;
  logic       prev_clk   = 1'b0;
  logic       prev_se    = 1'b1;
  logic       prev_tm    = 1'b1;
  logic       prev_start = 1'b0;
  logic [7:0] last_tx    = 8'h00;
  logic       rise_scan  = 1'b0;
  logic       rise_se    = 1'b0;
  logic       rise_tm    = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (csoc_clk && !prev_clk) begin
        rises++;
        rise_scan = scan_in;
        rise_se   = se;
        rise_tm   = tm;
        if (!se && !tm) run_rises++;
      end
      if (tx_start) begin
        tx_cnt++;
        last_tx = tx_data;
        if (prev_start) tx_long++;
      end
      if (!csoc_rstn) rstn_low++;
      if (csoc_clk && (se != prev_se || tm != prev_tm)) se_viol++;
    end
    prev_clk   = csoc_clk;
    prev_se    = se;
    prev_tm    = tm;
    prev_start = tx_start;
  end

  task automatic strobe(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    new_rx  = 1'b1;
    @(posedge clk); #1;
    new_rx  = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_idle_timeout", busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input int n, input string tag);
    logic [7:0] c;
    for (int i = 0; i < n; i++) begin
      c = (i % 2 == 1) ? 8'h48 : 8'h4C;
      strobe(c);
      wait_idle(20);
      check($sformatf("%s_scan%0d", tag, i), rise_scan, i % 2);
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         rises;
    int         run_rises;
    int         acks;
    logic [7:0] ack_data;
    int         rstn_low;
  } vec_t;

  vec_t vecs [8];

  int r0, rr0, t0, l0;
  int found;

  initial begin
    vecs[0] = '{8'h47, 6, 6, 1, 8'h4B, 0};  // "G": 6 functional clocks, "K"
    vecs[1] = '{8'h52, 0, 0, 1, 8'h4B, 4};  // "R": 4-cycle reset pulse, "K"
    vecs[2] = '{8'h5A, 0, 0, 1, 8'h3F, 0};  // "Z": unknown, "?"
    vecs[3] = '{8'h0A, 0, 0, 0, 8'h00, 0};  // "\n": ignored
    vecs[4] = '{8'h0D, 0, 0, 0, 8'h00, 0};  // "\r": ignored
    vecs[5] = '{8'h20, 0, 0, 0, 8'h00, 0};  // " ": ignored
    vecs[6] = '{8'h58, 0, 0, 1, 8'h4B, 0};  // "X": clear, "K"
    vecs[7] = '{8'h6C, 0, 0, 1, 8'h3F, 0};  // "l": lowercase is unknown, "?"

    rst      = 1'b1;
    rx_data  = 8'h00;
    new_rx   = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_csoc_clk", csoc_clk, 0);
    check("rst_rstn", csoc_rstn, 0);
    check("rst_se", se, 1);
    check("rst_tm", tm, 1);
    check("rst_scan_in", scan_in, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h4B);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_bit_cnt", dut.bit_cnt, 0);

    rst = 1'b0;
    check("rstn_held_until_edge", csoc_rstn, 0);
    @(posedge clk); #1;
    check("rstn_after_release", csoc_rstn, 1);

    // Test 1: first bit with exact timing, then 19 more alternating bits
    r0 = rises; t0 = tx_cnt;
    @(posedge clk); #1;
    rx_data = 8'h4C;
    new_rx  = 1'b1;
    @(posedge clk); #1;
    new_rx  = 1'b0;
    check("t1_setup_clk_low", csoc_clk, 0);
    check("t1_setup_scan_in", scan_in, 0);
    check("t1_setup_busy", busy, 1);
    @(posedge clk); #1;
    check("t1_high_clk", csoc_clk, 1);
    check("t1_high_se", se, 1);
    check("t1_high_tm", tm, 1);
    @(posedge clk); #1;
    check("t1_back_clk_low", csoc_clk, 0);
    check("t1_back_idle", busy, 0);
    check("t1_bit_cnt1", dut.bit_cnt, 1);
    for (int i = 1; i < 20; i++) begin
      strobe((i % 2 == 1) ? 8'h48 : 8'h4C);
      wait_idle(20);
      check($sformatf("t1_scan%0d", i), rise_scan, i % 2);
      check($sformatf("t1_se_tm%0d", i), {rise_se, rise_tm}, 2'b11);
      check($sformatf("t1_acks_after%0d", i), tx_cnt - t0, (i == 19) ? 1 : 0);
    end
    check("t1_rises", rises - r0, 20);
    check("t1_ack_data", last_tx, 8'h4B);
    check("t1_bit_cnt_wrapped", dut.bit_cnt, 0);

    // Table: single commands and their observable effects
    for (int i = 0; i < 8; i++) begin
      r0 = rises; rr0 = run_rises; t0 = tx_cnt; l0 = rstn_low;
      strobe(vecs[i].cmd);
      wait_idle(40);
      check($sformatf("vec%0d_rises", i), rises - r0, vecs[i].rises);
      check($sformatf("vec%0d_run_rises", i), run_rises - rr0, vecs[i].run_rises);
      check($sformatf("vec%0d_acks", i), tx_cnt - t0, vecs[i].acks);
      if (vecs[i].acks != 0)
        check($sformatf("vec%0d_ack_data", i), last_tx, vecs[i].ack_data);
      check($sformatf("vec%0d_rstn_low", i), rstn_low - l0, vecs[i].rstn_low);
      check($sformatf("vec%0d_idle_levels", i), {csoc_clk, csoc_rstn, se, tm}, 4'b0111);
    end

    // Test 3: "R" abandons a partial chain; a full 20 bits are needed again
    shift_bits(5, "t3a");
    check("t3_bit_cnt5", dut.bit_cnt, 5);
    t0 = tx_cnt; l0 = rstn_low;
    strobe(8'h52);
    wait_idle(20);
    check("t3_rstn_low4", rstn_low - l0, 4);
    check("t3_bit_cnt0", dut.bit_cnt, 0);
    check("t3_r_ack", tx_cnt - t0, 1);
    t0 = tx_cnt;
    shift_bits(19, "t3b");
    check("t3_no_ack_19", tx_cnt - t0, 0);
    shift_bits(1, "t3c");
    check("t3_ack_20", tx_cnt - t0, 1);
    check("t3_ack_data", last_tx, 8'h4B);

    // Test 5: ack blocked by the transmitter; extra byte is dropped
    shift_bits(19, "t5");
    t0 = tx_cnt; r0 = rises;
    tx_ready = 1'b0;
    strobe(8'h48);
    repeat (4) @(posedge clk);
    #1;
    check("t5_busy_waiting", busy, 1);
    check("t5_no_ack_yet", tx_cnt - t0, 0);
    check("t5_overrun_clear", overrun, 0);
    strobe(8'h48);
    repeat (3) @(posedge clk);
    #1;
    check("t5_overrun_set", overrun, 1);
    check("t5_still_busy", busy, 1);
    check("t5_dropped_no_clk", rises - r0, 1);
    tx_ready = 1'b1;
    wait_idle(20);
    check("t5_single_ack", tx_cnt - t0, 1);
    check("t5_ack_data", last_tx, 8'h4B);
    check("t5_overrun_sticky", overrun, 1);

    // Test 6: reset in the middle of a functional run
    shift_bits(3, "t6");
    check("t6_bit_cnt3", dut.bit_cnt, 3);
    strobe(8'h47);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (csoc_clk) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("t6_reached_run_hi", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_csoc_clk", csoc_clk, 0);
    check("t6_rstn", csoc_rstn, 0);
    check("t6_se", se, 1);
    check("t6_tm", tm, 1);
    check("t6_tx_start", tx_start, 0);
    check("t6_bit_cnt", dut.bit_cnt, 0);
    check("t6_overrun_cleared", overrun, 0);
    check("t6_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_rstn_released", csoc_rstn, 1);

    // Test 7: strobe on the cycle the FSM returns to IDLE is dropped
    r0 = rises; t0 = tx_cnt;
    @(posedge clk); #1;
    rx_data = 8'h58;
    new_rx  = 1'b1;
    @(posedge clk); #1;
    rx_data = 8'h4C;
    @(posedge clk); #1;
    new_rx  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t7_overrun", overrun, 1);
    check("t7_no_clk", rises - r0, 0);
    check("t7_one_ack", tx_cnt - t0, 1);
    check("t7_busy", busy, 0);

    check("se_tm_change_while_clk_high", se_viol, 0);
    check("tx_start_longer_than_1", tx_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
